// File: rtl/point_sequencer.sv
// Point sequencer: walks the point buffer once per frame, issuing draw/jump commands
// to a line drawer, holding a refresh floor per frame and parking the beam when idle.
module point_sequencer #(
    parameter logic [23:0] MIN_FRAME_CYCLES = 24'd500000,
    parameter logic [7:0]  JUMP_SETTLE      = 8'd16,
    parameter logic [23:0] PARK_XY          = 24'h800800
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_valid,
    input  logic [10:0] num_points,
    output logic [10:0] rd_addr,
    input  logic [24:0] rd_data,
    input  logic        ready,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        draw,
    output logic        jump,
    output logic        frame_done,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE, START, FETCH, WAIT_DATA, ISSUE, SETTLE, FRAME_END, PARK
    } state_t;

    localparam logic [23:0] FRAME_LAST  = (MIN_FRAME_CYCLES == 24'd0) ? 24'd0 : MIN_FRAME_CYCLES - 24'd1;
    localparam logic [7:0]  SETTLE_LAST = (JUMP_SETTLE == 8'd0) ? 8'd0 : JUMP_SETTLE - 8'd1;

    state_t      state, state_next;
    logic [10:0] npts;
    logic [24:0] point_p1;
    logic [23:0] frame_cnt;
    logic [7:0]  settle_cnt;
    logic [1:0]  since_cmd;
    logic        parked;

    logic cmd_ok, last_point, issue_cmd, park_cmd, done_cmd, advance;

    function automatic logic [23:0] sat_inc24(input logic [23:0] v);
        return (v == 24'hFFFFFF) ? v : v + 24'd1;
    endfunction

    function automatic logic [1:0] sat_inc2(input logic [1:0] v);
        return (v == 2'd3) ? v : v + 2'd1;
    endfunction

    // Two quiet cycles after a visible pulse keep commands 3 cycles apart, even FRAME_END->PARK.
    assign cmd_ok     = ready && (since_cmd >= 2'd2);
    assign last_point = ({1'b0, rd_addr} + 12'd1) == {1'b0, npts};
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        issue_cmd  = 1'b0;
        park_cmd   = 1'b0;
        done_cmd   = 1'b0;
        advance    = 1'b0;
        case (state)
            IDLE: begin
                if (frame_valid) begin
                    state_next = START;
                end else if (!parked) begin
                    state_next = PARK;
                end
            end
            START:     state_next = (num_points == 11'd0) ? FRAME_END : FETCH;
            FETCH:     state_next = WAIT_DATA;
            WAIT_DATA: state_next = ISSUE;
            ISSUE: begin
                if (cmd_ok) begin
                    issue_cmd = 1'b1;
                    if (!point_p1[24] && (JUMP_SETTLE != 8'd0)) begin
                        state_next = SETTLE;
                    end else if (last_point) begin
                        state_next = FRAME_END;
                    end else begin
                        state_next = FETCH;
                        advance    = 1'b1;
                    end
                end
            end
            SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    if (last_point) begin
                        state_next = FRAME_END;
                    end else begin
                        state_next = FETCH;
                        advance    = 1'b1;
                    end
                end
            end
            FRAME_END: begin
                if (frame_cnt >= FRAME_LAST) begin
                    done_cmd   = 1'b1;
                    state_next = frame_valid ? START : PARK;
                end
            end
            PARK: begin
                if (cmd_ok) begin
                    park_cmd   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Command outputs register one cycle after the decision edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x          <= 12'd0;
            y          <= 12'd0;
            draw       <= 1'b0;
            jump       <= 1'b0;
            frame_done <= 1'b0;
            rd_addr    <= 11'd0;
            parked     <= 1'b0;
            frame_cnt  <= 24'd0;
            settle_cnt <= 8'd0;
            since_cmd  <= 2'd3;
        end else begin
            draw       <= issue_cmd && point_p1[24];
            jump       <= (issue_cmd && !point_p1[24]) || park_cmd;
            frame_done <= done_cmd;
            if (issue_cmd) begin
                x <= point_p1[23:12];
                y <= point_p1[11:0];
            end else if (park_cmd) begin
                x <= PARK_XY[23:12];
                y <= PARK_XY[11:0];
            end
            since_cmd <= (issue_cmd || park_cmd) ? 2'd0 : sat_inc2(since_cmd);
            if (state == START) begin
                rd_addr <= 11'd0;
            end else if (advance) begin
                rd_addr <= rd_addr + 11'd1;
            end
            if (park_cmd) begin
                parked <= 1'b1;
            end else if (state_next == START) begin
                parked <= 1'b0;
            end
            // Cleared on entry so the START cycle itself is frame cycle 0.
            frame_cnt  <= (state_next == START) ? 24'd0 : sat_inc24(frame_cnt);
            settle_cnt <= (state == SETTLE) ? settle_cnt + 8'd1 : 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (state == START) begin
            npts <= num_points;
        end
        if (state == WAIT_DATA) begin
            point_p1 <= rd_data;
        end
    end

endmodule

// File: tb/tb_point_sequencer.sv
// Scoreboard bench for point_sequencer: a frame-level model queues the expected command
// stream and a negedge monitor checks pulses, held coordinates and frame_done timing.
module tb_point_sequencer;

    localparam logic [23:0] MIN_FRAME = 24'd10;
    localparam int          SETTLE    = 4;
    localparam logic [11:0] PARK_X    = 12'h800;
    localparam logic [11:0] PARK_Y    = 12'h800;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_valid = 1'b0;
    logic [10:0] num_points = 11'd0;
    logic        ready;
    logic [10:0] rd_addr;
    logic [24:0] rd_data;
    logic [11:0] x, y;
    logic        draw, jump, frame_done, busy;

    typedef struct {
        logic        is_draw;
        logic [11:0] cx;
        logic [11:0] cy;
        int          gap;
    } cmd_t;

    cmd_t        exp_q[$];
    logic [24:0] mem [0:15];
    logic [24:0] pts [0:15];

    int   checks = 0, failures = 0, cyc = 0;
    int   fd_cnt = 0, last_fd_cyc = -1, last_cmd_cyc = -100, rise_cyc = 0;
    bit   mon_off = 1'b1, exact_gap = 1'b0, exact_fd = 1'b0, rise_pending = 1'b0, ready_rand = 1'b0;
    logic ready_fixed = 1'b1, rnd_bit = 1'b1;
    logic [11:0] held_x = 12'd0, held_y = 12'd0;

    assign ready = ready_rand ? rnd_bit : ready_fixed;

    point_sequencer #(
        .MIN_FRAME_CYCLES(MIN_FRAME),
        .JUMP_SETTLE(8'd4),
        .PARK_XY(24'h800800)
    ) dut (
        .clk(clk),
        .reset(reset),
        .frame_valid(frame_valid),
        .num_points(num_points),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .ready(ready),
        .x(x),
        .y(y),
        .draw(draw),
        .jump(jump),
        .frame_done(frame_done),
        .busy(busy)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rd_data <= mem[rd_addr[3:0]];
    always @(negedge clk) rnd_bit <= ($urandom_range(0, 3) != 0);

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor: pops one expectation per visible command pulse.
    initial forever begin
        cmd_t e;
        @(negedge clk);
        if (!mon_off) begin
            if (draw && jump) chk("draw_jump_exclusive", 1, 0);
            if (draw || jump) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_cmd", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("cmd_kind_draw", int'(draw), int'(e.is_draw));
                    chk("cmd_x", int'(x), int'(e.cx));
                    chk("cmd_y", int'(y), int'(e.cy));
                    if (e.gap != 0) begin
                        if (exact_gap) chk("cmd_gap_exact", cyc - last_cmd_cyc, e.gap);
                        else chk("cmd_gap_min", int'(cyc - last_cmd_cyc >= e.gap), 1);
                    end
                end
                chk("cmd_spacing", int'(cyc - last_cmd_cyc >= 3), 1);
                if (rise_pending) begin
                    chk("ready_to_pulse", cyc, rise_cyc + 1);
                    rise_pending = 1'b0;
                end
                last_cmd_cyc = cyc;
                held_x = x;
                held_y = y;
            end else begin
                chk("x_held", int'(x), int'(held_x));
                chk("y_held", int'(y), int'(held_y));
            end
            if (frame_done) begin
                if (last_fd_cyc >= 0) begin
                    if (exact_fd) chk("frame_period", cyc - last_fd_cyc, int'(MIN_FRAME));
                    else chk("frame_period_min", int'(cyc - last_fd_cyc >= int'(MIN_FRAME)), 1);
                end
                fd_cnt++;
                last_fd_cyc = cyc;
            end
        end
    end

    task automatic rand_points(input int np);
        for (int i = 0; i < np; i++) pts[i] = {1'($urandom_range(0, 1)), 24'($urandom)};
    endtask

    task automatic load_points(input int np);
        for (int i = 0; i < 16; i++) begin
            if (i < np) mem[i] = pts[i];
            else mem[i] = {1'b1, 24'($urandom)};
        end
    endtask

    // One frame pass expects every point in order; in-frame spacing follows the previous kind.
    task automatic push_pass(input int np);
        for (int i = 0; i < np; i++) begin
            cmd_t e;
            e.is_draw = pts[i][24];
            e.cx      = pts[i][23:12];
            e.cy      = pts[i][11:0];
            e.gap     = (i == 0) ? 0 : (pts[i-1][24] ? 3 : 3 + SETTLE);
            exp_q.push_back(e);
        end
    endtask

    task automatic push_park();
        cmd_t e;
        e.is_draw = 1'b0;
        e.cx      = PARK_X;
        e.cy      = PARK_Y;
        e.gap     = 0;
        exp_q.push_back(e);
    endtask

    task automatic start_frames(input int np);
        fd_cnt      = 0;
        last_fd_cyc = cyc + 1;
        num_points  = 11'(np);
        frame_valid = 1'b1;
    endtask

    task automatic wait_busy();
        int n = 0;
        while (!busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("busy_rise", int'(busy), 1);
    endtask

    task automatic wait_drain(input int passes);
        int n = 0;
        while (exp_q.size() != 0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_remaining", exp_q.size(), 0);
        repeat (15) @(negedge clk);
        chk("busy_after_park", int'(busy), 0);
        chk("frame_done_count", fd_cnt, passes);
    endtask

    // Runs `passes` frame passes, then changes num_points and drops frame_valid mid-pass.
    task automatic run_frames(input int np, input int passes, input int np_after);
        int n = 0;
        for (int p = 0; p < passes; p++) push_pass(np);
        push_park();
        start_frames(np);
        if (passes == 1) begin
            wait_busy();
        end else begin
            while (fd_cnt < passes - 1 && n < 20000) begin
                @(negedge clk);
                n++;
            end
            chk("pass_reached", int'(fd_cnt >= passes - 1), 1);
        end
        @(negedge clk);
        num_points  = 11'(np_after);
        frame_valid = 1'b0;
        wait_drain(passes);
    endtask

    initial begin
        int n;
        int np;
        int passes;
        for (int i = 0; i < 16; i++) mem[i] = 25'd0;

        repeat (3) @(negedge clk);
        chk("reset_x", int'(x), 0);
        chk("reset_y", int'(y), 0);
        chk("reset_draw", int'(draw), 0);
        chk("reset_jump", int'(jump), 0);
        chk("reset_frame_done", int'(frame_done), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_rd_addr", int'(rd_addr), 0);
        push_park();
        reset   = 1'b0;
        mon_off = 1'b0;
        wait_drain(0);

        // Fixed three-point frame with ready tied high.
        pts[0] = {1'b1, 12'd100, 12'd200};
        pts[1] = {1'b0, 12'd300, 12'd400};
        pts[2] = {1'b1, 12'd500, 12'd600};
        load_points(3);
        exact_gap = 1'b1;
        run_frames(3, 3, 3);

        // num_points 3->7 and frame_valid drop in the same frame.
        rand_points(3);
        load_points(7);
        run_frames(3, 1, 7);
        exact_gap = 1'b0;

        // Empty frames pace frame_done at the refresh floor.
        exact_fd = 1'b1;
        run_frames(0, 4, 0);
        exact_fd = 1'b0;

        // Drawer stalls for 50 cycles in front of the first command.
        ready_fixed = 1'b0;
        rand_points(2);
        load_points(2);
        push_pass(2);
        push_park();
        start_frames(2);
        wait_busy();
        @(negedge clk);
        frame_valid = 1'b0;
        repeat (50) @(negedge clk);
        chk("hold_no_cmd", exp_q.size(), 3);
        rise_cyc     = cyc;
        rise_pending = 1'b1;
        ready_fixed  = 1'b1;
        wait_drain(1);
        chk("rise_consumed", int'(rise_pending), 0);

        // Random frames with a randomly stalling drawer.
        ready_rand = 1'b1;
        for (int k = 0; k < 4; k++) begin
            np     = $urandom_range(1, 12);
            passes = $urandom_range(1, 3);
            rand_points(np);
            load_points(np);
            run_frames(np, passes, np);
        end
        ready_rand  = 1'b0;
        ready_fixed = 1'b1;

        // Reset lands in the middle of a jump settle.
        pts[0] = {1'b1, 12'h123, 12'h456};
        pts[1] = {1'b0, 12'h321, 12'h654};
        pts[2] = {1'b1, 12'h111, 12'h222};
        load_points(3);
        push_pass(3);
        start_frames(3);
        n = 0;
        while (!(jump && x == 12'h321) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("settle_jump_seen", int'(jump), 1);
        @(negedge clk);
        mon_off     = 1'b1;
        reset       = 1'b1;
        frame_valid = 1'b0;
        #1;
        chk("mid_reset_x", int'(x), 0);
        chk("mid_reset_y", int'(y), 0);
        chk("mid_reset_draw", int'(draw), 0);
        chk("mid_reset_jump", int'(jump), 0);
        chk("mid_reset_frame_done", int'(frame_done), 0);
        chk("mid_reset_busy", int'(busy), 0);
        chk("mid_reset_rd_addr", int'(rd_addr), 0);
        exp_q.delete();
        @(negedge clk);
        chk("post_reset_no_pulse", int'(draw | jump), 0);
        chk("post_reset_no_frame_done", int'(frame_done), 0);
        held_x       = 12'd0;
        held_y       = 12'd0;
        last_cmd_cyc = -100;
        fd_cnt       = 0;
        last_fd_cyc  = -1;
        push_park();
        reset   = 1'b0;
        mon_off = 1'b0;
        wait_drain(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
